// File: rtl/token_matcher.sv
// token_matcher: run-time loadable vocabulary table scanned one character per
// cycle against an input word. Supports exact and longest-prefix matching and
// reports the hit index and match length with a one-cycle done strobe.
module token_matcher #(
    parameter int ADDR_WIDTH  = 4,
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int LEN_W       = $clog2(WORD_LENGTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] wr_word,
    input  logic                              mode,
    input  logic                              start,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
    output logic                              busy,
    output logic                              done,
    output logic                              found,
    output logic [ADDR_WIDTH-1:0]             index,
    output logic [LEN_W-1:0]                  match_len
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Character counter only needs to reach WORD_LENGTH-1.
    localparam int CW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

    // Element 0 sits in the MSBs, so word_t[c] is character c.
    typedef logic [0:WORD_LENGTH-1][DATA_WIDTH-1:0] word_t;
    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    word_t [DEPTH-1:0]     tbl;
    word_t                 word_in;
    word_t                 word_q;
    logic                  mode_q;
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] e, e_nxt;
    logic [CW-1:0]         c, c_nxt;
    logic [LEN_W-1:0]      best_len, best_len_nxt;
    logic [ADDR_WIDTH-1:0] best_idx, best_idx_nxt;
    logic [LEN_W-1:0]      in_len;
    logic [LEN_W-1:0]      full_len;
    logic [DATA_WIDTH-1:0] en_ch, in_ch;
    logic                  adv;

    assign word_in = word;
    assign en_ch   = tbl[e][c];
    assign in_ch   = word_q[c];
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // Length of the latched input word: position of its first zero character.
    always_comb begin
        in_len = LEN_W'(WORD_LENGTH);
        for (int i = WORD_LENGTH - 1; i >= 0; i--) begin
            if (word_q[i] == '0) in_len = LEN_W'(i);
        end
    end

    // Next-state and scan bookkeeping: one entry/character comparison per cycle.
    always_comb begin
        state_nxt    = state;
        e_nxt        = e;
        c_nxt        = c;
        best_len_nxt = best_len;
        best_idx_nxt = best_idx;
        full_len     = '0;
        adv          = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    e_nxt        = '0;
                    c_nxt        = '0;
                    best_len_nxt = '0;
                    best_idx_nxt = '0;
                    state_nxt    = (word_in[0] == '0) ? DONE : COMPARE;
                end
            end
            COMPARE: begin
                if (c == '0 && en_ch == '0) begin
                    // Empty entry.
                    adv = 1'b1;
                end else if (en_ch == in_ch && (en_ch == '0 || c == CW'(WORD_LENGTH - 1))) begin
                    // Entry and input end together (or fill the word): full match.
                    full_len = (en_ch == '0) ? LEN_W'(c) : LEN_W'(WORD_LENGTH);
                    if (full_len > best_len) begin
                        best_len_nxt = full_len;
                        best_idx_nxt = e;
                    end
                    if (!mode_q || full_len == in_len) state_nxt = DONE;
                    else adv = 1'b1;
                end else if (en_ch == in_ch) begin
                    c_nxt = c + 1'b1;
                end else begin
                    // Entry ended before the input did: it is a prefix (c>0 here).
                    if (en_ch == '0 && mode_q && LEN_W'(c) > best_len) begin
                        best_len_nxt = LEN_W'(c);
                        best_idx_nxt = e;
                    end
                    adv = 1'b1;
                end
                if (adv) begin
                    c_nxt = '0;
                    if (&e) state_nxt = DONE;
                    else e_nxt = e + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers and result capture on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_q    <= '0;
            mode_q    <= 1'b0;
            e         <= '0;
            c         <= '0;
            best_len  <= '0;
            best_idx  <= '0;
            found     <= 1'b0;
            index     <= '0;
            match_len <= '0;
        end else begin
            state    <= state_nxt;
            e        <= e_nxt;
            c        <= c_nxt;
            best_len <= best_len_nxt;
            best_idx <= best_idx_nxt;
            if (state == IDLE && start) begin
                word_q <= word_in;
                mode_q <= mode;
            end
            if (state != DONE && state_nxt == DONE) begin
                found     <= (best_len_nxt != '0);
                index     <= best_idx_nxt;
                match_len <= best_len_nxt;
            end
        end
    end

    // Vocabulary table; writes are dropped while a scan is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl <= '0;
        end else if (wr_en && !busy) begin
            tbl[wr_addr] <= wr_word;
        end
    end

endmodule
